// File: rtl/voice_param_scheduler_if.sv
// Register-file read port and FM datapath result bus of the voice scheduler.
// master: scheduler side (drives addresses/strobes/results); slave: RAM, flags, datapath.
interface voice_param_scheduler_if;
   logic [9:0]  IO_R_Mem_addr;
   logic [17:0] IO_R_Mem_value;
   logic        IO_Flag_read;
   logic [3:0]  IO_Flag_addr;
   logic [1:0]  IO_Flag_value;
   logic        IO_Param_valid;
   logic [3:0]  IO_Param_voice;
   logic [3:0]  IO_Param_index;
   logic [17:0] IO_Param_value;
   logic        IO_Key_valid;
   logic [1:0]  IO_Key_event;
   logic        IO_Frame_done;
   logic        IO_Overrun;

   modport master (
      output IO_R_Mem_addr, IO_Flag_read, IO_Flag_addr,
      output IO_Param_valid, IO_Param_voice, IO_Param_index,
      output IO_Param_value, IO_Key_valid, IO_Key_event,
      output IO_Frame_done, IO_Overrun,
      input  IO_R_Mem_value, IO_Flag_value
   );

   modport slave (
      input  IO_R_Mem_addr, IO_Flag_read, IO_Flag_addr,
      input  IO_Param_valid, IO_Param_voice, IO_Param_index,
      input  IO_Param_value, IO_Key_valid, IO_Key_event,
      input  IO_Frame_done, IO_Overrun,
      output IO_R_Mem_value, IO_Flag_value
   );
endinterface

// File: rtl/voice_param_scheduler.sv
// Per-sample sweep of voice event flags and parameter RAM into the FM datapath.
// Ports: IO_main_clk, IO_reset (async, high), bus (master modport of
// voice_param_scheduler_if); IO_Sample_tick only with VOICE_SCHED_EXT_TICK_EN.
module voice_param_scheduler #(
   parameter int NUM_VOICES       = 8,
   parameter int PARAMS_PER_VOICE = 4,
   parameter int ADDR_BASE        = 0,
   parameter int MEM_LATENCY      = 1,
   parameter int SAMPLE_DIV       = 512
) (
   input logic IO_main_clk,
   input logic IO_reset,
`ifdef VOICE_SCHED_EXT_TICK_EN
   input logic IO_Sample_tick,
`endif
   voice_param_scheduler_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, FLAG_RD, FLAG_CAP, PARAM_RD, DRAIN
   } state_t;

   localparam logic [3:0] LAST_V = 4'(NUM_VOICES - 1);
   localparam logic [3:0] LAST_P = 4'(PARAMS_PER_VOICE - 1);
   localparam logic [1:0] LAST_D = 2'(MEM_LATENCY - 1);

   state_t      state;
   logic [3:0]  voice;
   logic [3:0]  param;
   logic [1:0]  drain_cnt;
   logic [9:0]  next_addr;
   logic        tick;
   logic        issue;
   logic [3:0]  issue_idx;

   // Tags travel alongside each outstanding read until its data returns.
   logic        pv     [MEM_LATENCY];
   logic [3:0]  pvoice [MEM_LATENCY];
   logic [3:0]  pidx   [MEM_LATENCY];

`ifdef VOICE_SCHED_EXT_TICK_EN
   assign tick = IO_Sample_tick;
`else
   localparam int DW = $clog2(SAMPLE_DIV + 1);
   logic [DW-1:0] div_q;

   assign tick = (div_q == DW'(SAMPLE_DIV - 1));

   always_ff @(posedge IO_main_clk or posedge IO_reset) begin
      if (IO_reset) div_q <= '0;
      else if (tick) div_q <= '0;
      else div_q <= div_q + 1'b1;
   end
`endif

   // Address for p0 is loaded leaving FLAG_CAP; later ones while in PARAM_RD.
   always_comb begin
      issue     = 1'b0;
      issue_idx = '0;
      if (state == FLAG_CAP) begin
         issue = 1'b1;
      end else if (state == PARAM_RD && param != LAST_P) begin
         issue     = 1'b1;
         issue_idx = param + 4'd1;
      end
   end

   always_ff @(posedge IO_main_clk or posedge IO_reset) begin
      if (IO_reset) begin
         state              <= IDLE;
         voice              <= '0;
         param              <= '0;
         drain_cnt          <= '0;
         next_addr          <= 10'(ADDR_BASE);
         for (int i = 0; i < MEM_LATENCY; i++) begin
            pv[i]     <= 1'b0;
            pvoice[i] <= '0;
            pidx[i]   <= '0;
         end
         bus.IO_R_Mem_addr  <= '0;
         bus.IO_Flag_read   <= 1'b0;
         bus.IO_Flag_addr   <= '0;
         bus.IO_Param_valid <= 1'b0;
         bus.IO_Param_voice <= '0;
         bus.IO_Param_index <= '0;
         bus.IO_Param_value <= '0;
         bus.IO_Key_valid   <= 1'b0;
         bus.IO_Key_event   <= '0;
         bus.IO_Frame_done  <= 1'b0;
         bus.IO_Overrun     <= 1'b0;
      end else begin
         bus.IO_Key_valid  <= 1'b0;
         bus.IO_Frame_done <= 1'b0;

         if (tick && state != IDLE)
            bus.IO_Overrun <= 1'b1;

         pv[0]     <= issue;
         pvoice[0] <= voice;
         pidx[0]   <= issue_idx;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            pv[i]     <= pv[i-1];
            pvoice[i] <= pvoice[i-1];
            pidx[i]   <= pidx[i-1];
         end

         bus.IO_Param_valid <= pv[MEM_LATENCY-1];
         if (pv[MEM_LATENCY-1]) begin
            bus.IO_Param_voice <= pvoice[MEM_LATENCY-1];
            bus.IO_Param_index <= pidx[MEM_LATENCY-1];
            bus.IO_Param_value <= bus.IO_R_Mem_value;
         end

         // Voices are contiguous in RAM, so one running counter suffices.
         if (issue) begin
            bus.IO_R_Mem_addr <= next_addr;
            next_addr         <= next_addr + 10'd1;
         end

         unique case (state)
            IDLE: begin
               if (tick) begin
                  state            <= FLAG_RD;
                  voice            <= '0;
                  next_addr        <= 10'(ADDR_BASE);
                  bus.IO_Flag_read <= 1'b1;
                  bus.IO_Flag_addr <= '0;
               end
            end
            FLAG_RD: begin
               bus.IO_Flag_read <= 1'b0;
               state            <= FLAG_CAP;
            end
            FLAG_CAP: begin
               param <= '0;
               state <= PARAM_RD;
               if (bus.IO_Flag_value != 2'b00) begin
                  bus.IO_Key_valid   <= 1'b1;
                  bus.IO_Key_event   <= bus.IO_Flag_value;
                  bus.IO_Param_voice <= voice;
               end
            end
            PARAM_RD: begin
               if (param == LAST_P) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end else begin
                  param <= param + 4'd1;
               end
            end
            DRAIN: begin
               if (drain_cnt == LAST_D) begin
                  drain_cnt <= '0;
                  if (voice == LAST_V) begin
                     state             <= IDLE;
                     bus.IO_Frame_done <= 1'b1;
                  end else begin
                     voice            <= voice + 4'd1;
                     state            <= FLAG_RD;
                     bus.IO_Flag_read <= 1'b1;
                     bus.IO_Flag_addr <= voice + 4'd1;
                  end
               end else begin
                  drain_cnt <= drain_cnt + 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_voice_param_scheduler.sv
// Directed bench for voice_param_scheduler: three configurations
// (defaults, wrapped addresses with latency 3, short sample divider).
module tb_voice_param_scheduler;

   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   logic arm_a;
   int   arm_idx;
   logic [1:0] arm_val;
   int   checks, errors;

   always #5 clk = ~clk;

   voice_param_scheduler_if bus_a ();
   voice_param_scheduler_if bus_b ();
   voice_param_scheduler_if bus_c ();

`ifdef VOICE_SCHED_EXT_TICK_EN
   int   ecnt_a, ecnt_b, ecnt_c;
   logic tick_a, tick_b, tick_c;
   always @(posedge clk or posedge rst_a)
      if (rst_a) ecnt_a <= 0; else ecnt_a <= ecnt_a + 1;
   always @(posedge clk or posedge rst_b)
      if (rst_b) ecnt_b <= 0; else ecnt_b <= ecnt_b + 1;
   always @(posedge clk or posedge rst_c)
      if (rst_c) ecnt_c <= 0; else ecnt_c <= ecnt_c + 1;
   assign tick_a = !rst_a && ((ecnt_a + 1) % 512 == 0);
   assign tick_b = !rst_b && ((ecnt_b + 1) % 512 == 0);
   assign tick_c = !rst_c && ((ecnt_c + 1) % 40 == 0);
`endif

   voice_param_scheduler u_a (
      .IO_main_clk    (clk),
      .IO_reset       (rst_a),
`ifdef VOICE_SCHED_EXT_TICK_EN
      .IO_Sample_tick (tick_a),
`endif
      .bus            (bus_a)
   );

   voice_param_scheduler #(
      .PARAMS_PER_VOICE (2),
      .ADDR_BASE        (1020),
      .MEM_LATENCY      (3)
   ) u_b (
      .IO_main_clk    (clk),
      .IO_reset       (rst_b),
`ifdef VOICE_SCHED_EXT_TICK_EN
      .IO_Sample_tick (tick_b),
`endif
      .bus            (bus_b)
   );

   voice_param_scheduler #(
      .SAMPLE_DIV (40)
   ) u_c (
      .IO_main_clk    (clk),
      .IO_reset       (rst_c),
`ifdef VOICE_SCHED_EXT_TICK_EN
      .IO_Sample_tick (tick_c),
`endif
      .bus            (bus_c)
   );

   // RAM[k] = 0x100 + k. Latency 1: data follows the address register.
   assign bus_a.IO_R_Mem_value = 18'h100 + 18'(bus_a.IO_R_Mem_addr);
   assign bus_c.IO_R_Mem_value = 18'h100 + 18'(bus_c.IO_R_Mem_addr);
   assign bus_c.IO_Flag_value  = 2'b00;
   assign bus_b.IO_Flag_value  = 2'b00;

   // Latency 3: two extra register stages on the address.
   logic [9:0] d1_b, d2_b;
   always @(posedge clk) begin
      d1_b <= bus_b.IO_R_Mem_addr;
      d2_b <= d1_b;
   end
   assign bus_b.IO_R_Mem_value = 18'h100 + 18'(d2_b);

   // Clear-on-read flag file for instance A.
   logic [31:0] flags_a;
   always @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         flags_a             <= '0;
         bus_a.IO_Flag_value <= '0;
      end else begin
         bus_a.IO_Flag_value <= '0;
         if (arm_a) flags_a[2*arm_idx +: 2] <= arm_val;
         if (bus_a.IO_Flag_read) begin
            bus_a.IO_Flag_value <=
               flags_a[2*int'(bus_a.IO_Flag_addr) +: 2];
            flags_a[2*int'(bus_a.IO_Flag_addr) +: 2] <= 2'b00;
         end
      end
   end

   logic [46:0] outs_a;
   assign outs_a = {bus_a.IO_R_Mem_addr, bus_a.IO_Flag_read,
                    bus_a.IO_Flag_addr, bus_a.IO_Param_valid,
                    bus_a.IO_Param_voice, bus_a.IO_Param_index,
                    bus_a.IO_Param_value, bus_a.IO_Key_valid,
                    bus_a.IO_Key_event, bus_a.IO_Frame_done,
                    bus_a.IO_Overrun};

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge where FLAG_RD of voice 0 is visible.
   task automatic frame_a(input int key_voice);
      int words = 0, reads = 0, keys = 0, dones = 0;
      int first = -1, done_at = -1;
      for (int k = 0; k < 70; k++) begin
         if (bus_a.IO_Flag_read) begin
            chk("a_flag_addr", 64'(bus_a.IO_Flag_addr), 64'(reads));
            reads++;
         end
         if (bus_a.IO_Param_valid) begin
            if (first < 0) first = k;
            chk("a_voice", 64'(bus_a.IO_Param_voice), 64'(words / 4));
            chk("a_index", 64'(bus_a.IO_Param_index), 64'(words % 4));
            chk("a_value", 64'(bus_a.IO_Param_value), 64'(256 + words));
            words++;
         end
         if (bus_a.IO_Key_valid) begin
            keys++;
            chk("a_key_voice", 64'(bus_a.IO_Param_voice), 64'(key_voice));
            chk("a_key_event", 64'(bus_a.IO_Key_event), 64'd2);
            chk("a_key_before_p0", 64'(words), 64'(key_voice * 4));
         end
         if (bus_a.IO_Frame_done) begin
            dones++;
            done_at = k;
         end
         @(negedge clk);
      end
      chk("a_flag_reads", 64'(reads), 64'd8);
      chk("a_words", 64'(words), 64'd32);
      chk("a_first_valid", 64'(first), 64'd3);
      chk("a_done_cycle", 64'(done_at), 64'd56);
      chk("a_done_count", 64'(dones), 64'd1);
      chk("a_keys", 64'(keys), 64'((key_voice < 0) ? 0 : 1));
   endtask

   initial begin
      int n, nd, words, first, done_at, last_rd;
      checks = 0; errors = 0;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      arm_a = 1'b0; arm_idx = 0; arm_val = 2'b00;
      repeat (3) @(negedge clk);
      chk("a_reset_outputs", 64'(outs_a), 64'd0);

      // Instance A, frame 1: no events.
      rst_a = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!bus_a.IO_Flag_read && n < 600);
      chk("a_first_tick", 64'(n), 64'd512);
      frame_a(-1);

      // Frame 2: event on voice 3.
      arm_a = 1'b1; arm_idx = 3; arm_val = 2'b10;
      @(negedge clk);
      arm_a = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!bus_a.IO_Flag_read && n < 600);
      chk("a_period_2", 64'(n), 64'd441);
      frame_a(3);

      // Frame 3: flag was cleared by the read.
      n = 0;
      do begin @(negedge clk); n++; end
      while (!bus_a.IO_Flag_read && n < 600);
      chk("a_period_3", 64'(n), 64'd442);
      frame_a(-1);
      chk("a_no_overrun", 64'(bus_a.IO_Overrun), 64'd0);

      // Frame 4: reset during voice 4 PARAM_RD.
      n = 0;
      do begin @(negedge clk); n++; end
      while (!bus_a.IO_Flag_read && n < 600);
      chk("a_period_4", 64'(n), 64'd442);
      repeat (30) @(negedge clk);
      chk("a_v4_addr", 64'(bus_a.IO_R_Mem_addr), 64'd16);
      rst_a = 1'b1;
      #1;
      chk("a_mid_reset_outputs", 64'(outs_a), 64'd0);
      @(negedge clk);
      rst_a = 1'b0;
      n = 0; nd = 0;
      do begin
         @(negedge clk); n++;
         if (bus_a.IO_Frame_done) nd++;
      end while (!bus_a.IO_Flag_read && n < 600);
      chk("a_no_done_after_reset", 64'(nd), 64'd0);
      chk("a_restart_tick", 64'(n), 64'd512);
      chk("a_restart_voice", 64'(bus_a.IO_Flag_addr), 64'd0);
      repeat (3) @(negedge clk);
      chk("a_restart_valid", 64'(bus_a.IO_Param_valid), 64'd1);
      chk("a_restart_word", 64'({bus_a.IO_Param_voice,
          bus_a.IO_Param_index, bus_a.IO_Param_value}), 64'h00100);
      rst_a = 1'b1;

      // Instance B: base 1020, 2 params, latency 3.
      rst_b = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!bus_b.IO_Flag_read && n < 600);
      chk("b_first_tick", 64'(n), 64'd512);
      words = 0; first = -1; done_at = -1;
      for (int k = 0; k < 70; k++) begin
         if (bus_b.IO_Param_valid) begin
            if (first < 0) first = k;
            chk("b_voice", 64'(bus_b.IO_Param_voice), 64'(words / 2));
            chk("b_index", 64'(bus_b.IO_Param_index), 64'(words % 2));
            chk("b_value", 64'(bus_b.IO_Param_value),
                64'(256 + ((1020 + words) % 1024)));
            words++;
         end
         if (bus_b.IO_Frame_done && done_at < 0) done_at = k;
         @(negedge clk);
      end
      chk("b_words", 64'(words), 64'd16);
      chk("b_first_valid", 64'(first), 64'd5);
      chk("b_done_cycle", 64'(done_at), 64'd56);
      rst_b = 1'b1;

      // Instance C: 40-cycle divider, 56-cycle frame.
      rst_c = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!bus_c.IO_Flag_read && n < 100);
      chk("c_first_tick", 64'(n), 64'd40);
      done_at = -1; last_rd = -1;
      for (int k = 0; k < 86; k++) begin
         if (k == 39)
            chk("c_overrun_before", 64'(bus_c.IO_Overrun), 64'd0);
         if (k == 40)
            chk("c_overrun_rise", 64'(bus_c.IO_Overrun), 64'd1);
         if (bus_c.IO_Frame_done && done_at < 0) done_at = k;
         if (bus_c.IO_Flag_read && k > 56 && last_rd < 0) begin
            last_rd = k;
            chk("c_restart_voice", 64'(bus_c.IO_Flag_addr), 64'd0);
         end
         @(negedge clk);
      end
      chk("c_done_cycle", 64'(done_at), 64'd56);
      chk("c_next_frame", 64'(last_rd), 64'd80);
      chk("c_overrun_sticky", 64'(bus_c.IO_Overrun), 64'd1);
      rst_c = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
